mux_nto1_reg: RTL and testbench
===============================

Name: mux_nto1_reg

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every input channel and on the single output.
- Next generation of the team's 2:1 dataflow mux. Adds generic channel count and width, a registered output stage, backpressure, and two selection modes.
- Mode 0 uses an external select. Mode 1 is an auto-scan round-robin pointer.
- Sits between multiple producer streams and one shared consumer.

Parameters:
- WIDTH, 8, data bits per channel (>=1)
- N, 4, number of input channels (>=2)
- SELW, $clog2(N), select/channel-index width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (one-hot or zero)
- sel  input  SELW  channel select, used in mode 0
- mode  input  1  0 = manual select, 1 = auto-scan
- out_data  output  WIDTH  registered output data
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word
- out_chan  output  SELW  source channel index of out_data

Behaviour:
- Single clock domain. Reset is asynchronous active-low. On rst_n=0, immediately and independent of clk:
  - out_valid=0, out_data=0, out_chan=0
  - scan_ptr=0
  - in_ready=0
- Reset mid-transfer drops any held word; no word is emitted after release until a new accept occurs.
- Current channel: cur = mode ? scan_ptr : sel.
- cur is out of range when cur >= N (mode 0 only, for non-power-of-2 N). In that case:
  - in_ready is all zero
  - no accept occurs
  - the output register still drains normally
- can_load = !out_valid || out_ready.
- in_ready[k] = can_load && (k == cur) && cur in range. This is combinational from out_valid, out_ready, sel, mode and scan_ptr. There is no combinational path from in_valid to in_ready.
- Accept happens on a clk edge when in_valid[cur] && in_ready[cur]. Then:
  - out_data <= in_data slice cur
  - out_chan <= cur
  - out_valid <= 1
- Drain: out_valid && out_ready with no accept on the same edge -> out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous drain and accept on the same edge: the new word replaces the old one and out_valid stays 1. Full throughput is 1 word/cycle.
- Latency is 1 cycle from accept edge to out_valid=1.
- Stall: while out_valid && !out_ready, out_data, out_chan and out_valid are stable. All in_ready are 0.
- Scan pointer (scan_ptr, SELW bits) advances only while mode=1:
  - on an accept edge: scan_ptr <= next(scan_ptr)
  - if in_valid[scan_ptr]=0 (empty-channel skip): scan_ptr <= next(scan_ptr)
  - if in_valid[scan_ptr]=1 but not accepted (stall): scan_ptr holds
  - next(p) = (p == N-1) ? 0 : p+1; it wraps N-1 -> 0 and never reaches values >= N
- While mode=0, scan_ptr holds its value.
- Mode switches take effect combinationally on cur in the same cycle. scan_ptr is not reset by a mode change.
- Every channel whose index is not cur sees in_ready=0, so its valid/data must be held by the producer per the handshake rule.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0. Assert rst_n=0 asynchronously mid-cycle while out_valid=1 -> out_valid drops before the next clk edge.
- Mode 0 streaming, N=4, WIDTH=8: set mode=0, sel=2, in_data ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. One cycle later out_data=8'hA5, out_chan=2, out_valid=1. Repeat each cycle -> 1 word/cycle.
- Backpressure: with a word held, set out_ready=0 for 3 cycles -> out_data stable, in_ready=0. Set out_ready=1 -> drain and accept occur on the same edge and out_valid stays 1.
- Auto-scan: mode=1, in_valid=4'b1011, out_ready=1 -> out_chan sequence 0,1,3,0,1,3; channel 2 is skipped and scan_ptr wraps from 3 to 0.
- Auto-scan stall: mode=1, scan_ptr=1, in_valid[1]=1, out_ready=0 with out_valid=1 -> scan_ptr holds at 1 until out_ready=1.
- Out-of-range select (N=3, SELW=2): mode=0, sel=3, in_valid=3'b111 -> in_ready=0, no accept, out_valid stays 0. Set sel=0 -> accept on the next edge.

Source files
------------

// File: rtl/mux_nto1_reg.sv
// N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every
// input channel and on the output; manual select (mode 0) or round-robin scan (mode 1).
module mux_nto1_reg #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_chan
);

    localparam logic [SELW:0]   NUM_CH  = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);

    logic [SELW-1:0]  cur_s;
    logic             cur_in_range_s;
    logic [WIDTH-1:0] cur_data_s;
    logic             cur_valid_s;
    logic             can_load_s;
    logic             accept_s;
    logic [SELW-1:0]  scan_step_s;

    logic [WIDTH-1:0] out_data_d,  out_data_q;
    logic [SELW-1:0]  out_chan_d,  out_chan_q;
    logic             out_valid_d, out_valid_q;
    logic [SELW-1:0]  scan_ptr_d,  scan_ptr_q;

    // Current channel; a manual select beyond N-1 names no channel at all
    always_comb begin
        cur_s          = mode ? scan_ptr_q : sel;
        cur_in_range_s = ({1'b0, cur_s} < NUM_CH);
    end

    // Data/valid of the current channel as an AND-OR mux over all channels
    always_comb begin
        cur_data_s  = '0;
        cur_valid_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            cur_data_s  = cur_data_s | ({WIDTH{cur_s == SELW'(k)}} & in_data[k*WIDTH +: WIDTH]);
            cur_valid_s = cur_valid_s | ((cur_s == SELW'(k)) & in_valid[k]);
        end
    end

    // Handshake: ready never depends on in_valid, and is forced low while in reset
    always_comb begin
        can_load_s = !out_valid_q || out_ready;
        if (rst_n && can_load_s && cur_in_range_s) begin
            in_ready = N'(1) << cur_s;
        end else begin
            in_ready = '0;
        end
        accept_s = can_load_s && cur_in_range_s && cur_valid_s;
    end

    // Scan pointer moves on an accept or past an empty channel, holds on a stall
    always_comb begin
        scan_step_s = (scan_ptr_q == LAST_CH) ? '0 : scan_ptr_q + SELW'(1);
        if (mode && (accept_s || !cur_valid_s)) begin
            scan_ptr_d = scan_step_s;
        end else begin
            scan_ptr_d = scan_ptr_q;
        end
    end

    // Output register: load on accept, empty on drain, otherwise hold
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (accept_s) begin
            out_data_d  = cur_data_s;
            out_chan_d  = cur_s;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State flops with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            scan_ptr_q  <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            scan_ptr_q  <= scan_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Directed bench for mux_nto1_reg: a 4-channel instance checked against a scoreboard
// of expected output words, and a 3-channel instance for the out-of-range select.
module tb_mux_nto1_reg;

    localparam int W  = 8;
    localparam int NA = 4;
    localparam int SA = 2;
    localparam int NB = 3;
    localparam int SB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NA*W-1:0] a_in_data;
    logic [NA-1:0]   a_in_valid, a_in_ready;
    logic [SA-1:0]   a_sel, a_out_chan;
    logic            a_mode, a_out_valid, a_out_ready;
    logic [W-1:0]    a_out_data;

    logic [NB*W-1:0] b_in_data;
    logic [NB-1:0]   b_in_valid, b_in_ready;
    logic [SB-1:0]   b_sel, b_out_chan;
    logic            b_mode, b_out_valid, b_out_ready;
    logic [W-1:0]    b_out_data;

    mux_nto1_reg #(.WIDTH(W), .N(NA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .mode(a_mode), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_chan(a_out_chan)
    );

    mux_nto1_reg #(.WIDTH(W), .N(NB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .mode(b_mode), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chan(b_out_chan)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SA-1:0] chan;
    } word_t;

    word_t         sb_q[$];
    logic [SA-1:0] m_scan;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of DUT A: check ready, predict accept/drain, then check the output register
    task automatic tick_a(input string tag);
        logic [SA-1:0] cur;
        logic          inr, can_load, acc;
        logic [NA-1:0] exp_rdy;
        word_t         w;
        #1;
        cur      = a_mode ? m_scan : a_sel;
        inr      = (int'(cur) < NA);
        can_load = (sb_q.size() == 0) || a_out_ready;
        exp_rdy  = '0;
        if (can_load && inr) exp_rdy[cur] = 1'b1;
        chk({tag, ".in_ready"}, 64'(a_in_ready), 64'(exp_rdy));
        acc = can_load && inr && a_in_valid[cur];
        if (sb_q.size() > 0 && a_out_ready) void'(sb_q.pop_front());
        if (acc) begin
            w.data = a_in_data[cur*W +: W];
            w.chan = cur;
            sb_q.push_back(w);
        end
        if (a_mode && (acc || !a_in_valid[m_scan]))
            m_scan = (m_scan == SA'(NA - 1)) ? '0 : m_scan + SA'(1);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 64'(a_out_valid), 64'(sb_q.size() > 0));
        if (sb_q.size() > 0) begin
            chk({tag, ".out_data"}, 64'(a_out_data), 64'(sb_q[0].data));
            chk({tag, ".out_chan"}, 64'(a_out_chan), 64'(sb_q[0].chan));
        end
    endtask

    task automatic set_a(input int ch, input logic [W-1:0] d);
        a_in_data[ch*W +: W] = d;
    endtask

    logic [SA-1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    int            n_seq;

    initial begin
        a_in_data = '0; a_in_valid = '1; a_sel = '0; a_mode = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '1; b_sel = '0; b_mode = 1'b0; b_out_ready = 1'b1;
        m_scan = '0;
        #12;
        chk("rst.a.out_valid", 64'(a_out_valid), 64'(0));
        chk("rst.a.out_data",  64'(a_out_data),  64'(0));
        chk("rst.a.out_chan",  64'(a_out_chan),  64'(0));
        chk("rst.a.in_ready",  64'(a_in_ready),  64'(0));
        chk("rst.b.in_ready",  64'(b_in_ready),  64'(0));
        chk("rst.b.out_valid", 64'(b_out_valid), 64'(0));
        b_in_valid = '0;
        rst_n = 1'b1;

        // Manual select streaming, one word per cycle
        a_sel = 2'd2; a_in_valid = 4'b0100; set_a(2, 8'hA5);
        tick_a("m0.a5");
        chk("m0.a5.data", 64'(a_out_data), 64'(8'hA5));
        chk("m0.a5.chan", 64'(a_out_chan), 64'(2));
        set_a(2, 8'h5A); tick_a("m0.5a");
        set_a(2, 8'h3C); tick_a("m0.3c");
        chk("m0.3c.data", 64'(a_out_data), 64'(8'h3C));
        a_sel = 2'd0; a_in_valid = 4'b0001; set_a(0, 8'h11); tick_a("m0.ch0");
        a_sel = 2'd3; a_in_valid = 4'b1000; set_a(3, 8'h33); tick_a("m0.ch3");

        // Backpressure: held word stable, then drain and accept on one edge
        a_out_ready = 1'b0; set_a(3, 8'h44);
        for (int i = 0; i < 3; i++) begin
            tick_a("bp.stall");
            chk("bp.stall.data", 64'(a_out_data), 64'(8'h33));
        end
        a_out_ready = 1'b1; tick_a("bp.release");
        chk("bp.release.data", 64'(a_out_data), 64'(8'h44));
        a_in_valid = '0; tick_a("bp.drain");

        // Auto-scan with channel 2 empty
        a_mode = 1'b1; a_in_valid = 4'b1011;
        set_a(0, 8'hC0); set_a(1, 8'hC1); set_a(2, 8'hC2); set_a(3, 8'hC3);
        n_seq = 0;
        for (int i = 0; i < 8; i++) begin
            tick_a("scan");
            if (a_out_valid) begin
                if (n_seq < 6) chk("scan.seq", 64'(a_out_chan), 64'(exp_seq[n_seq]));
                n_seq++;
            end
        end
        chk("scan.count", 64'(n_seq), 64'(6));

        // Scan stall at pointer 1
        tick_a("stall.load0");
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick_a("stall.hold");
        a_out_ready = 1'b1; tick_a("stall.go");
        chk("stall.go.chan", 64'(a_out_chan), 64'(1));

        // Mode change keeps the scan pointer (now 2)
        a_mode = 1'b0; a_sel = 2'd0; a_in_valid = 4'b0001; tick_a("msw.manual");
        a_mode = 1'b1; a_in_valid = 4'b1111; tick_a("msw.scan");
        chk("msw.scan.chan", 64'(a_out_chan), 64'(2));

        // Asynchronous reset mid-cycle with a word held
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(a_out_valid), 64'(0));
        chk("arst.out_data",  64'(a_out_data),  64'(0));
        chk("arst.in_ready",  64'(a_in_ready),  64'(0));
        sb_q.delete();
        m_scan = '0;
        #1;
        rst_n = 1'b1;
        a_mode = 1'b0; a_in_valid = '0; tick_a("arst.idle");
        chk("arst.idle.data", 64'(a_out_data), 64'(0));
        a_sel = 2'd1; a_in_valid = 4'b0010; tick_a("arst.new");

        // Out-of-range manual select on the 3-channel instance
        b_mode = 1'b0; b_sel = 2'd3; b_in_valid = 3'b111; b_in_data[0 +: W] = 8'h77;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("oor.in_ready", 64'(b_in_ready), 64'(0));
            @(posedge clk);
            #1;
            chk("oor.out_valid", 64'(b_out_valid), 64'(0));
        end
        b_sel = 2'd0;
        #1;
        chk("oor.sel0.in_ready", 64'(b_in_ready), 64'(3'b001));
        @(posedge clk);
        #1;
        chk("oor.sel0.out_valid", 64'(b_out_valid), 64'(1));
        chk("oor.sel0.out_data",  64'(b_out_data),  64'(8'h77));
        chk("oor.sel0.out_chan",  64'(b_out_chan),  64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
